// File: rtl/console_writer.sv
// console_writer: text-console front end sitting between a character source
// and the vram write port. Owns the cursor, issues every vram write (glyphs,
// backspace erase, line clears), and scrolls the display by advancing top_row
// and blanking the freshly exposed line.
module console_writer #(
  parameter int          COLS           = 100,
  parameter int          ROWS           = 30,
  parameter int          COL_BITS       = 7,
  parameter int          ROW_BITS       = 5,
  parameter logic [7:0]  BLANK          = 8'h20,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_char_valid,
  output logic                o_char_ready,
  input  logic [7:0]          i_char_data,
  output logic                o_vram_write_valid,
  input  logic                i_vram_write_ready,
  output logic [ROW_BITS-1:0] o_vram_write_row,
  output logic [COL_BITS-1:0] o_vram_write_col,
  output logic [7:0]          o_vram_write_char,
  output logic [ROW_BITS-1:0] o_top_row,
  output logic [ROW_BITS-1:0] o_cursor_row,
  output logic [COL_BITS-1:0] o_cursor_col,
  output logic                o_busy
);

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_PUT,
    S_CLEAR
  } state_t;

  // The power-up clear is optional; without it we come up ready for input.
  localparam state_t RESET_STATE = CLEAR_ON_RESET ? S_INIT : S_IDLE;

  // Explicit end-of-range constants: COLS/ROWS need not be powers of two, so
  // counters are always wrapped by comparison, never by overflow.
  localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(COLS - 1);
  localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(ROWS - 1);
  localparam logic [COL_BITS-1:0] COL_ONE  = COL_BITS'(1);
  localparam logic [ROW_BITS-1:0] ROW_ONE  = ROW_BITS'(1);

  localparam logic [7:0] CODE_BS = 8'h08;
  localparam logic [7:0] CODE_LF = 8'h0A;
  localparam logic [7:0] CODE_CR = 8'h0D;

  state_t r_state, w_state;

  logic                r_valid,  w_valid;
  logic [ROW_BITS-1:0] r_wrow,   w_wrow;
  logic [COL_BITS-1:0] r_wcol,   w_wcol;
  logic [7:0]          r_wchar,  w_wchar;
  logic [ROW_BITS-1:0] r_crow,   w_crow;
  logic [COL_BITS-1:0] r_ccol,   w_ccol;
  logic [ROW_BITS-1:0] r_top,    w_top;
  logic                r_put_bs, w_put_bs;

  logic                w_do_nl;
  logic                w_printable;
  logic [ROW_BITS-1:0] w_nl_row;
  logic [ROW_BITS-1:0] w_nl_top;
  logic                w_nl_scroll;

  // Where a newline would land, and whether landing there needs a scroll
  // because the ring has come round to the row currently shown at the top.
  assign w_nl_row    = (r_crow == LAST_ROW) ? '0 : r_crow + ROW_ONE;
  assign w_nl_top    = (r_top == LAST_ROW) ? '0 : r_top + ROW_ONE;
  assign w_nl_scroll = (w_nl_row == r_top);
  assign w_printable = (i_char_data >= 8'h20) && (i_char_data <= 8'h7E);

  // Next-state and next-datapath decode; every register holds by default.
  always_comb begin
    w_state  = r_state;
    w_valid  = r_valid;
    w_wrow   = r_wrow;
    w_wcol   = r_wcol;
    w_wchar  = r_wchar;
    w_crow   = r_crow;
    w_ccol   = r_ccol;
    w_top    = r_top;
    w_put_bs = r_put_bs;
    w_do_nl  = 1'b0;

    case (r_state)
      S_INIT: begin
        if (!r_valid) begin
          w_valid = 1'b1;
          w_wrow  = '0;
          w_wcol  = '0;
          w_wchar = BLANK;
        end else if (i_vram_write_ready) begin
          if (r_wcol == LAST_COL) begin
            w_wcol = '0;
            if (r_wrow == LAST_ROW) begin
              w_valid = 1'b0;
              w_state = S_IDLE;
            end else begin
              w_wrow = r_wrow + ROW_ONE;
            end
          end else begin
            w_wcol = r_wcol + COL_ONE;
          end
        end
      end

      S_IDLE: begin
        if (i_char_valid) begin
          if (w_printable) begin
            w_state  = S_PUT;
            w_valid  = 1'b1;
            w_wrow   = r_crow;
            w_wcol   = r_ccol;
            w_wchar  = i_char_data;
            w_put_bs = 1'b0;
          end else if (i_char_data == CODE_CR) begin
            w_ccol = '0;
          end else if (i_char_data == CODE_LF) begin
            w_do_nl = 1'b1;
          end else if (i_char_data == CODE_BS) begin
            if (r_ccol != '0) begin
              w_ccol   = r_ccol - COL_ONE;
              w_state  = S_PUT;
              w_valid  = 1'b1;
              w_wrow   = r_crow;
              w_wcol   = r_ccol - COL_ONE;
              w_wchar  = BLANK;
              w_put_bs = 1'b1;
            end
          end
        end
      end

      S_PUT: begin
        if (i_vram_write_ready) begin
          w_valid = 1'b0;
          w_state = S_IDLE;
          if (!r_put_bs) begin
            if (r_ccol == LAST_COL) begin
              w_do_nl = 1'b1;
            end else begin
              w_ccol = r_ccol + COL_ONE;
            end
          end
        end
      end

      S_CLEAR: begin
        if (i_vram_write_ready) begin
          if (r_wcol == LAST_COL) begin
            w_valid = 1'b0;
            w_state = S_IDLE;
          end else begin
            w_wcol = r_wcol + COL_ONE;
          end
        end
      end

      default: begin
        w_state = S_IDLE;
        w_valid = 1'b0;
      end
    endcase

    if (w_do_nl) begin
      w_ccol  = '0;
      w_crow  = w_nl_row;
      if (w_nl_scroll) begin
        w_top = w_nl_top;
      end
      w_state = S_CLEAR;
      w_valid = 1'b1;
      w_wrow  = w_nl_row;
      w_wcol  = '0;
      w_wchar = BLANK;
    end
  end

  // State register; reset restarts the power-up clear if it is enabled.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= RESET_STATE;
    end else begin
      r_state <= w_state;
    end
  end

  // Write port, cursor and scroll registers; reset abandons any pending beat.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_valid  <= 1'b0;
      r_wrow   <= '0;
      r_wcol   <= '0;
      r_wchar  <= '0;
      r_crow   <= '0;
      r_ccol   <= '0;
      r_top    <= '0;
      r_put_bs <= 1'b0;
    end else begin
      r_valid  <= w_valid;
      r_wrow   <= w_wrow;
      r_wcol   <= w_wcol;
      r_wchar  <= w_wchar;
      r_crow   <= w_crow;
      r_ccol   <= w_ccol;
      r_top    <= w_top;
      r_put_bs <= w_put_bs;
    end
  end

  assign o_char_ready       = (r_state == S_IDLE);
  assign o_busy             = (r_state != S_IDLE);
  assign o_vram_write_valid = r_valid;
  assign o_vram_write_row   = r_wrow;
  assign o_vram_write_col   = r_wcol;
  assign o_vram_write_char  = r_wchar;
  assign o_top_row          = r_top;
  assign o_cursor_row       = r_crow;
  assign o_cursor_col       = r_ccol;

endmodule

// File: tb/tb_console_writer.sv
// tb_console_writer: scoreboard bench for console_writer on a tiny 4x3 screen.
// A text-console model predicts every vram write and the cursor/top_row after
// each character; a monitor pops and compares each completed write beat.
module tb_console_writer;

  localparam int COLS = 4;
  localparam int ROWS = 3;
  localparam int CB   = 2;
  localparam int RB   = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          charValid = 1'b0;
  logic [7:0]    charData = 8'h00;
  logic          ready = 1'b1;
  logic          charReady;
  logic          wrValid;
  logic [RB-1:0] wrRow;
  logic [CB-1:0] wrCol;
  logic [7:0]    wrChar;
  logic [RB-1:0] topRow;
  logic [RB-1:0] cursorRow;
  logic [CB-1:0] cursorCol;
  logic          busy;

  console_writer #(
    .COLS(COLS), .ROWS(ROWS), .COL_BITS(CB), .ROW_BITS(RB),
    .BLANK(8'h20), .CLEAR_ON_RESET(1'b1)
  ) dut (
    .i_clk(clk),
    .i_reset(reset),
    .i_char_valid(charValid),
    .o_char_ready(charReady),
    .i_char_data(charData),
    .o_vram_write_valid(wrValid),
    .i_vram_write_ready(ready),
    .o_vram_write_row(wrRow),
    .o_vram_write_col(wrCol),
    .o_vram_write_char(wrChar),
    .o_top_row(topRow),
    .o_cursor_row(cursorRow),
    .o_cursor_col(cursorCol),
    .o_busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [RB-1:0] row;
    logic [CB-1:0] col;
    logic [7:0]    ch;
  } beat_t;

  beat_t expQ[$];
  int checks = 0;
  int errors = 0;
  int readyMode = 0;
  int mRow = 0;
  int mCol = 0;
  int mTop = 0;

  // Ready driver: 0 = tied high, 1 = random back-pressure, 2 = held low.
  always @(posedge clk) begin
    #1;
    case (readyMode)
      0:       ready = 1'b1;
      1:       ready = ($urandom_range(0, 3) != 0);
      default: ready = 1'b0;
    endcase
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic pushBeat(input int r, input int c, input logic [7:0] ch);
    beat_t b;
    b.row = RB'(r);
    b.col = CB'(c);
    b.ch  = ch;
    expQ.push_back(b);
  endtask

  task automatic modelInit();
    expQ.delete();
    mRow = 0;
    mCol = 0;
    mTop = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        pushBeat(r, c, 8'h20);
  endtask

  task automatic modelNewline();
    mCol = 0;
    mRow = (mRow + 1) % ROWS;
    if (mRow == mTop) mTop = (mTop + 1) % ROWS;
    for (int c = 0; c < COLS; c++) pushBeat(mRow, c, 8'h20);
  endtask

  task automatic modelAccept(input logic [7:0] ch);
    if (ch >= 8'h20 && ch <= 8'h7E) begin
      pushBeat(mRow, mCol, ch);
      if (mCol == COLS - 1) modelNewline();
      else mCol++;
    end else if (ch == 8'h0D) begin
      mCol = 0;
    end else if (ch == 8'h0A) begin
      modelNewline();
    end else if (ch == 8'h08) begin
      if (mCol > 0) begin
        mCol--;
        pushBeat(mRow, mCol, 8'h20);
      end
    end
  endtask

  // Monitor: compare each completed beat with the scoreboard and require a
  // stalled beat to keep valid and its payload unchanged until accepted.
  beat_t held;
  logic  stalled = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        checks++;
        if (!wrValid || {wrRow, wrCol, wrChar} != held) begin
          errors++;
          $display("[TB] FAIL beatStable got v=%0b (%0d,%0d,%02h) expected v=1 (%0d,%0d,%02h)",
                   wrValid, wrRow, wrCol, wrChar, held.row, held.col, held.ch);
        end
      end
      if (wrValid && ready) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpectedBeat got (%0d,%0d,%02h) expected no write",
                   wrRow, wrCol, wrChar);
        end else begin
          beat_t e;
          e = expQ.pop_front();
          if ({wrRow, wrCol, wrChar} != e) begin
            errors++;
            $display("[TB] FAIL beat got (%0d,%0d,%02h) expected (%0d,%0d,%02h)",
                     wrRow, wrCol, wrChar, e.row, e.col, e.ch);
          end
        end
        stalled = 1'b0;
      end else if (wrValid) begin
        stalled = 1'b1;
        held    = {wrRow, wrCol, wrChar};
      end else begin
        stalled = 1'b0;
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] ch);
    int n;
    n = 0;
    @(negedge clk);
    while (!charReady && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!charReady) begin
      checks++;
      errors++;
      $display("[TB] FAIL acceptTimeout got char_ready=0 expected 1");
      return;
    end
    charValid = 1'b1;
    charData  = ch;
    modelAccept(ch);
    @(posedge clk);
    #1 charValid = 1'b0;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    @(negedge clk);
    while (!(charReady && !busy && expQ.size() == 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      checks++;
      errors++;
      $display("[TB] FAIL idleTimeout got busy=%0b pending=%0d expected idle with 0 pending",
               busy, expQ.size());
    end
  endtask

  task automatic checkModelCursor();
    checkOutput("cursorRow", int'(cursorRow), mRow);
    checkOutput("cursorCol", int'(cursorCol), mCol);
    checkOutput("topRow", int'(topRow), mTop);
  endtask

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog got no finish expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int r;
    int stallRow;
    logic [7:0] ch;

    // Power-up: reset held, then the 12-cell clear.
    modelInit();
    repeat (3) @(negedge clk);
    checkOutput("resetValid", int'(wrValid), 0);
    checkOutput("resetCursorRow", int'(cursorRow), 0);
    checkOutput("resetCursorCol", int'(cursorCol), 0);
    checkOutput("resetTopRow", int'(topRow), 0);
    reset = 1'b0;
    waitIdle();
    checkOutput("initDoneReady", int'(charReady), 1);
    checkOutput("initDoneBusy", int'(busy), 0);
    checkModelCursor();

    // Single printable: write on the cycle after acceptance.
    applyStimulus(8'h41);
    @(negedge clk);
    checkOutput("putLatencyValid", int'(wrValid), 1);
    checkOutput("putRow", int'(wrRow), 0);
    checkOutput("putCol", int'(wrCol), 0);
    checkOutput("putChar", int'(wrChar), 8'h41);
    waitIdle();
    checkOutput("afterACol", int'(cursorCol), 1);

    // CR back to column 0, then ABCD to force an auto-wrap.
    applyStimulus(8'h0D);
    waitIdle();
    checkOutput("crCol", int'(cursorCol), 0);
    applyStimulus(8'h41); waitIdle();
    applyStimulus(8'h42); waitIdle();
    applyStimulus(8'h43); waitIdle();
    applyStimulus(8'h44);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("wrapBeatValid", int'(wrValid), 1);
      checkOutput("wrapCharReady", int'(charReady), 0);
    end
    waitIdle();
    checkOutput("wrapRow", int'(cursorRow), 1);
    checkOutput("wrapCol", int'(cursorCol), 0);
    checkOutput("wrapTop", int'(topRow), 0);

    // Walk to (2,3), then two LFs that each scroll.
    applyStimulus(8'h0A); waitIdle();
    applyStimulus(8'h61); waitIdle();
    applyStimulus(8'h62); waitIdle();
    applyStimulus(8'h63); waitIdle();
    checkOutput("preScrollRow", int'(cursorRow), 2);
    checkOutput("preScrollCol", int'(cursorCol), 3);
    applyStimulus(8'h0A); waitIdle();
    checkOutput("scroll1Row", int'(cursorRow), 0);
    checkOutput("scroll1Top", int'(topRow), 1);
    applyStimulus(8'h0A); waitIdle();
    checkOutput("scroll2Row", int'(cursorRow), 1);
    checkOutput("scroll2Top", int'(topRow), 2);

    // Backspace, CR and an ignored control code.
    applyStimulus(8'h78); waitIdle();
    applyStimulus(8'h79); waitIdle();
    applyStimulus(8'h08); waitIdle();
    checkOutput("bsCol", int'(cursorCol), 1);
    applyStimulus(8'h08); waitIdle();
    applyStimulus(8'h08); waitIdle();
    checkOutput("bsAtZeroCol", int'(cursorCol), 0);
    checkOutput("bsAtZeroRow", int'(cursorRow), 1);
    applyStimulus(8'h70); waitIdle();
    applyStimulus(8'h71); waitIdle();
    applyStimulus(8'h72); waitIdle();
    checkOutput("preCrCol", int'(cursorCol), 3);
    applyStimulus(8'h0D); waitIdle();
    checkOutput("crAt3Col", int'(cursorCol), 0);
    applyStimulus(8'h07); waitIdle();
    checkModelCursor();

    // Back-pressure: ready held low for five cycles during a PUT.
    stallRow  = mRow;
    readyMode = 2;
    @(posedge clk);
    #2;
    applyStimulus(8'h5A);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("stallValid", int'(wrValid), 1);
      checkOutput("stallRow", int'(wrRow), stallRow);
      checkOutput("stallCol", int'(wrCol), 0);
      checkOutput("stallChar", int'(wrChar), 8'h5A);
    end
    readyMode = 0;
    @(negedge clk);
    checkOutput("stallReleaseValid", int'(wrValid), 1);
    @(negedge clk);
    checkOutput("stallDoneValid", int'(wrValid), 0);
    waitIdle();
    checkModelCursor();

    // Randomised traffic with random back-pressure.
    readyMode = 1;
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      if (r < 55)      ch = 8'($urandom_range(32, 126));
      else if (r < 67) ch = 8'h0A;
      else if (r < 75) ch = 8'h0D;
      else if (r < 88) ch = 8'h08;
      else if (r < 94) ch = 8'h07;
      else             ch = 8'($urandom_range(127, 255));
      applyStimulus(ch);
      waitIdle();
      checkModelCursor();
    end

    // Reset in the middle of a stalled CLEAR.
    readyMode = 2;
    @(posedge clk);
    #2;
    applyStimulus(8'h0A);
    @(negedge clk);
    @(negedge clk);
    checkOutput("midClearValid", int'(wrValid), 1);
    reset = 1'b1;
    #1;
    checkOutput("asyncResetValid", int'(wrValid), 0);
    checkOutput("asyncResetRow", int'(cursorRow), 0);
    checkOutput("asyncResetCol", int'(cursorCol), 0);
    checkOutput("asyncResetTop", int'(topRow), 0);
    checkOutput("asyncResetReady", int'(charReady), 0);
    modelInit();
    readyMode = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    waitIdle();
    checkOutput("reinitBusy", int'(busy), 0);
    checkModelCursor();

    checkOutput("pendingBeats", expQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/console_writer.md
Name: console_writer

Overview:
- Text-console front end between a character source (ps2 scan-code path or a later keymap/UART stage) and the vram write port.
- Manages a cursor and performs all vram writes: printable glyphs, backspace erase, line clears.
- Handles CR/LF/BS, auto-wrap at end of line, and hardware scroll.
- Scroll is done by advancing top_row, which feeds the hdmi scan-out, plus clearing the newly exposed line.

Parameters:
COLS, 100, characters per row; legal range 2..2^COL_BITS.
ROWS, 30, rows in the ring; legal range 2..2^ROW_BITS.
COL_BITS, 7, width of column fields.
ROW_BITS, 5, width of row fields.
BLANK, 8'h20, character written when erasing or clearing.
CLEAR_ON_RESET, 1, if 1, the whole screen is cleared after reset release.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
char_valid  in  1  source has a character
char_ready  out  1  block accepts a character this cycle
char_data  in  8  character code
vram_write_valid  out  1  write request
vram_write_ready  in  1  vram accepts the write
vram_write_row  out  ROW_BITS  physical row of the write
vram_write_col  out  COL_BITS  column of the write
vram_write_char  out  8  character to write
top_row  out  ROW_BITS  physical row shown at the top of the screen (to hdmi)
cursor_row  out  ROW_BITS  current physical cursor row
cursor_col  out  COL_BITS  current cursor column
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values (asynchronous): vram_write_valid=0, cursor_row=0, cursor_col=0, top_row=0, write row/col/char=0.
- Reset state is INIT if CLEAR_ON_RESET=1, otherwise IDLE.
- char_ready = (state==IDLE). A character is accepted when char_valid && char_ready.
- States:
  - INIT: clear all ROWS*COLS cells, row-major from (0,0); then IDLE.
  - IDLE: wait for a character.
  - PUT: one write beat; then IDLE or NEWLINE.
  - CLEAR: COLS beats writing BLANK to the row held in cursor_row, cols 0..COLS-1; then IDLE.
- Acceptance decode (cycle N):
  - 0x20..0x7E: go to PUT with row=cursor_row, col=cursor_col, char=char_data.
  - 0x0D (CR): cursor_col<=0; stay IDLE; no write.
  - 0x0A (LF): newline.
  - 0x08 (BS):
    - cursor_col>0: cursor_col<=cursor_col-1, then PUT BLANK at the new column.
    - cursor_col==0: no-op.
  - Any other code: consumed and dropped; no state change.
- Write beats:
  - vram_write_valid rises at cycle N+1.
  - Row/col/char are held stable and valid stays high until the cycle vram_write_ready=1.
  - valid never drops without ready.
  - Back-to-back beats are allowed, one per cycle, while ready stays high.
- After a printable PUT completes:
  - cursor_col<COLS-1: cursor_col+1.
  - cursor_col==COLS-1: auto-wrap newline.
  - A BS PUT does not advance the cursor.
- Newline (registered in one cycle):
  - cursor_col<=0.
  - next = (cursor_row==ROWS-1) ? 0 : cursor_row+1; cursor_row<=next.
  - If next==top_row: top_row<=(top_row==ROWS-1) ? 0 : top_row+1 (scroll).
  - Then CLEAR.
  - LF latency: CLEAR's first beat is at N+1.
  - Auto-wrap latency: CLEAR's first beat follows the final PUT beat by one cycle.
- Every newline clears its target row, scrolled or not.
- Counters are compared against ROWS-1 / COLS-1 explicitly; never rely on natural binary wrap.
- reset asserted mid-beat:
  - valid drops immediately; the partial beat is abandoned.
  - Cursor and top_row return to 0; INIT restarts.

Test Plan:
- Params COLS=4, ROWS=3, CLEAR_ON_RESET=1, ready tied high:
  - Release reset -> exactly 12 BLANK beats, (0,0)..(2,3) row-major, then char_ready=1 and busy=0.
  - Send 'A' -> single beat (0,0,0x41) on the cycle after acceptance; cursor_col=1.
- Send 'ABCD' -> writes at cols 0..3 of row 0 -> auto-wrap: cursor=(1,0), 4 BLANK beats on row 1, top_row=0, char_ready low throughout.
- From cursor (2,3) with top_row=0, send LF -> cursor_row=0, top_row=1, row 0 cleared. A second LF -> cursor_row=1, top_row=2.
- BS at col 2 -> one write (row,1,0x20), cursor_col=1. BS at col 0 -> no write, cursor unchanged. CR at col 3 -> cursor_col=0, no write. 0x07 -> accepted, no effect.
- Hold ready=0 for 5 cycles during a PUT -> valid and row/col/char stable all 5 cycles; the beat completes on the ready cycle.
- Assert reset while ready=0 mid-CLEAR -> valid=0 in the same cycle, cursor/top_row=0, INIT re-runs 12 beats.
